// File: rtl/morse_pkg.sv
// Shared types for the Morse key front end and the downstream character decoder.
package morse_pkg;

    // Symbol codes delivered on sym_o.
    typedef enum logic [1:0] {
        DOT        = 2'd0,
        DASH       = 2'd1,
        LETTER_END = 2'd2,
        WORD_END   = 2'd3
    } sym_t;

    // Key classifier phases.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } key_state_t;

endpackage : morse_pkg

// File: rtl/morse_key_classifier_debounce.sv
// Level debouncer: the output follows the input only after the input has held
// a different value for DEBOUNCE_CYCLES consecutive cycles.
module debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_WIDTH       = 32
) (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic level_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 level_r;
    logic [CNT_WIDTH-1:0] db_cnt_r;

    // Count consecutive disagreeing cycles; adopt the input on the last one.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_r  <= 1'b0;
            db_cnt_r <= CNT_ZERO;
        end else if (level_i != level_r) begin
            if (db_cnt_r == CNT_LAST) begin
                level_r  <= level_i;
                db_cnt_r <= CNT_ZERO;
            end else begin
                level_r  <= level_r;
                db_cnt_r <= db_cnt_r + CNT_ONE;
            end
        end else begin
            level_r  <= level_r;
            db_cnt_r <= CNT_ZERO;
        end
    end

    assign level_o = level_r;

endmodule : debounce

// File: rtl/morse_key_classifier.sv
// Morse key classifier: debounces the synchronized key, times presses and gaps,
// and hands DOT / DASH / LETTER_END / WORD_END symbols to the character
// decoder through a one-entry valid/ready register with a sticky drop flag.
module morse_key_classifier
    import morse_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int DOT_MAX_CYCLES    = 20_000_000,
    parameter int LETTER_GAP_CYCLES = 30_000_000,
    parameter int WORD_GAP_CYCLES   = 70_000_000,
    parameter int CNT_WIDTH         = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_i,
    output logic [1:0] sym_o,
    output logic       sym_valid_o,
    input  logic       sym_ready_i,
    output logic       overflow_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    // The rise cycle is seen before PRESS is entered, so a press has lasted
    // dur_r + 1 cycles when its fall is seen; DASH_MIN accounts for that.
    localparam logic [CNT_WIDTH-1:0] DASH_MIN    = CNT_WIDTH'(DOT_MAX_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LETTER_LAST = CNT_WIDTH'(LETTER_GAP_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] WORD_LAST   = CNT_WIDTH'(WORD_GAP_CYCLES - 1);

    logic                 key_db_s;
    key_state_t           state_r;
    key_state_t           next_state_s;
    logic [CNT_WIDTH-1:0] dur_r;
    logic                 letter_sent_r;
    logic                 evt_valid_s;
    sym_t                 evt_sym_s;
    logic                 letter_set_s;
    logic                 letter_clr_s;
    logic                 load_ok_s;
    sym_t                 sym_r;
    logic                 sym_valid_r;
    logic                 overflow_r;

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .level_i (key_i),
        .level_o (key_db_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: IDLE and GAP imply key released, PRESS implies held,
    // so the debounced level alone identifies the edges.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE: begin
                if (key_db_s) begin
                    next_state_s = PRESS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            PRESS: begin
                if (key_db_s) begin
                    next_state_s = PRESS;
                end else begin
                    next_state_s = GAP;
                end
            end
            GAP: begin
                if (key_db_s) begin
                    next_state_s = PRESS;
                end else if (dur_r == WORD_LAST) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = GAP;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Symbol generation; a rise in GAP always suppresses gap symbols.
    always_comb begin
        evt_valid_s  = 1'b0;
        evt_sym_s    = DOT;
        letter_set_s = 1'b0;
        letter_clr_s = 1'b0;
        case (state_r)
            IDLE: begin
                evt_valid_s = 1'b0;
            end
            PRESS: begin
                if (!key_db_s) begin
                    evt_valid_s  = 1'b1;
                    evt_sym_s    = (dur_r >= DASH_MIN) ? DASH : DOT;
                    letter_clr_s = 1'b1;
                end else begin
                    evt_valid_s = 1'b0;
                end
            end
            GAP: begin
                if (key_db_s) begin
                    evt_valid_s = 1'b0;
                end else if (dur_r == WORD_LAST) begin
                    evt_valid_s = 1'b1;
                    evt_sym_s   = WORD_END;
                end else if ((dur_r == LETTER_LAST) && !letter_sent_r) begin
                    evt_valid_s  = 1'b1;
                    evt_sym_s    = LETTER_END;
                    letter_set_s = 1'b1;
                end else begin
                    evt_valid_s = 1'b0;
                end
            end
            default: begin
                evt_valid_s = 1'b0;
            end
        endcase
    end

    // Phase duration: restarts on every state change, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            dur_r <= CNT_ZERO;
        end else if (next_state_s != state_r) begin
            dur_r <= CNT_ZERO;
        end else if (dur_r != CNT_MAX) begin
            dur_r <= dur_r + CNT_ONE;
        end else begin
            dur_r <= dur_r;
        end
    end

    // Remember that the current gap already produced its LETTER_END.
    always_ff @(posedge clk) begin
        if (reset) begin
            letter_sent_r <= 1'b0;
        end else if (letter_clr_s) begin
            letter_sent_r <= 1'b0;
        end else if (letter_set_s) begin
            letter_sent_r <= 1'b1;
        end else begin
            letter_sent_r <= letter_sent_r;
        end
    end

    assign load_ok_s = !sym_valid_r || sym_ready_i;

    // One-entry output register; a full, stalled register drops new symbols.
    always_ff @(posedge clk) begin
        if (reset) begin
            sym_r       <= DOT;
            sym_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            if (evt_valid_s && load_ok_s) begin
                sym_r       <= evt_sym_s;
                sym_valid_r <= 1'b1;
            end else if (sym_valid_r && sym_ready_i) begin
                sym_r       <= sym_r;
                sym_valid_r <= 1'b0;
            end else begin
                sym_r       <= sym_r;
                sym_valid_r <= sym_valid_r;
            end
            if (evt_valid_s && !load_ok_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

    assign sym_o       = sym_r;
    assign sym_valid_o = sym_valid_r;
    assign overflow_o  = overflow_r;

endmodule : morse_key_classifier

// File: tb/tb_morse_key_classifier.sv
// Directed bench for morse_key_classifier with short timing parameters.
// Timeline model: key_i raised in cycle k for M cycles gives key_db high for
// M cycles starting k+4; the press symbol is valid in cycle k+M+5, LETTER_END
// in k+M+25 and WORD_END in k+M+55 when the key stays released.
module tb_morse_key_classifier;
    import morse_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_i = 1'b0;
    logic       sym_ready_i = 1'b1;
    logic [1:0] sym_o;
    logic       sym_valid_o;
    logic       overflow_o;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    logic [1:0] q_sym[$];
    int         q_cyc[$];

    morse_key_classifier #(
        .DEBOUNCE_CYCLES   (4),
        .DOT_MAX_CYCLES    (10),
        .LETTER_GAP_CYCLES (20),
        .WORD_GAP_CYCLES   (50),
        .CNT_WIDTH         (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_i       (key_i),
        .sym_o       (sym_o),
        .sym_valid_o (sym_valid_o),
        .sym_ready_i (sym_ready_i),
        .overflow_o  (overflow_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed transfer with the cycle it happened in.
    always @(negedge clk) begin
        if (!reset && sym_valid_o && sym_ready_i) begin
            q_sym.push_back(sym_o);
            q_cyc.push_back(cyc);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input int m);
        key_i = 1'b1;
        tick(m);
        key_i = 1'b0;
    endtask

    task automatic expect_sym(input string tag, input int idx, input logic [1:0] s, input int c);
        check({tag, "_present"}, 32'(q_sym.size() > idx), 32'd1);
        if (q_sym.size() > idx) begin
            check({tag, "_sym"}, 32'(q_sym[idx]), 32'(s));
            check({tag, "_cycle"}, 32'(q_cyc[idx]), 32'(c));
        end
    endtask

    task automatic clear_q();
        q_sym.delete();
        q_cyc.delete();
    endtask

    int k;
    int ks[4];
    int lens[4] = '{15, 10, 9, 6};
    int gaps[4] = '{6, 6, 12, 0};
    logic [1:0] exp_syms[4] = '{2'd1, 2'd1, 2'd0, 2'd0};

    initial begin
        // Reset state.
        tick(2);
        check("rst_valid", 32'(sym_valid_o), 32'd0);
        check("rst_sym", 32'(sym_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        check("rst_state", 32'(dut.state_r), 32'(IDLE));
        reset = 1'b0;
        tick(1);

        // 3-cycle glitch is filtered.
        pulse(3);
        tick(10);
        check("glitch_keydb", 32'(dut.key_db_s), 32'd0);
        check("glitch_nosym", 32'(q_sym.size()), 32'd0);

        // 4-cycle pulse passes the debouncer and is a DOT.
        clear_q();
        k = cyc;
        key_i = 1'b1;
        tick(4);
        check("pulse4_keydb", 32'(dut.key_db_s), 32'd1);
        key_i = 1'b0;
        tick(66);
        expect_sym("p4_dot", 0, 2'd0, k + 9);
        expect_sym("p4_letter", 1, 2'd2, k + 29);
        expect_sym("p4_word", 2, 2'd3, k + 59);
        check("p4_count", 32'(q_sym.size()), 32'd3);

        // 6-cycle DOT, then letter and word gaps, then silence.
        clear_q();
        k = cyc;
        pulse(6);
        tick(60);
        expect_sym("dot6", 0, 2'd0, k + 11);
        expect_sym("dot6_letter", 1, 2'd2, k + 31);
        expect_sym("dot6_word", 2, 2'd3, k + 61);
        tick(200);
        check("silence_count", 32'(q_sym.size()), 32'd3);
        check("silence_state", 32'(dut.state_r), 32'(IDLE));

        // Press lengths 15, 10, 9, 6 with short gaps; the 12-cycle gap
        // ends before the letter threshold.
        clear_q();
        for (int i = 0; i < 4; i++) begin
            ks[i] = cyc;
            pulse(lens[i]);
            tick(gaps[i]);
        end
        tick(62);
        for (int i = 0; i < 4; i++) begin
            expect_sym($sformatf("seq%0d", i), i, exp_syms[i], ks[i] + lens[i] + 5);
        end
        expect_sym("seq_letter", 4, 2'd2, ks[3] + 6 + 25);
        expect_sym("seq_word", 5, 2'd3, ks[3] + 6 + 55);
        check("seq_count", 32'(q_sym.size()), 32'd6);

        // Back-pressure: DOT held, following DASH dropped, overflow sticky.
        clear_q();
        sym_ready_i = 1'b0;
        k = cyc;
        pulse(6);
        tick(6);
        check("bp_valid1", 32'(sym_valid_o), 32'd1);
        check("bp_sym1", 32'(sym_o), 32'd0);
        check("bp_ovf_before", 32'(overflow_o), 32'd0);
        pulse(12);
        tick(8);
        check("bp_valid2", 32'(sym_valid_o), 32'd1);
        check("bp_sym_held", 32'(sym_o), 32'd0);
        check("bp_ovf_set", 32'(overflow_o), 32'd1);
        check("bp_no_xfer", 32'(q_sym.size()), 32'd0);
        sym_ready_i = 1'b1;
        tick(1);
        check("bp_drained", 32'(sym_valid_o), 32'd0);
        check("bp_ovf_sticky", 32'(overflow_o), 32'd1);
        tick(50);
        expect_sym("bp_dot", 0, 2'd0, k + 32);
        expect_sym("bp_letter", 1, 2'd2, k + 49);
        expect_sym("bp_word", 2, 2'd3, k + 79);
        check("bp_count", 32'(q_sym.size()), 32'd3);
        check("bp_ovf_end", 32'(overflow_o), 32'd1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("bp_ovf_cleared", 32'(overflow_o), 32'd0);
        check("bp_valid_cleared", 32'(sym_valid_o), 32'd0);

        // Reset in the middle of a press emits nothing.
        clear_q();
        tick(2);
        key_i = 1'b1;
        tick(12);
        check("mid_state", 32'(dut.state_r), 32'(PRESS));
        check("mid_dur", 32'(dut.dur_r), 32'd7);
        reset = 1'b1;
        key_i = 1'b0;
        tick(1);
        check("mid_rst_state", 32'(dut.state_r), 32'(IDLE));
        check("mid_rst_keydb", 32'(dut.key_db_s), 32'd0);
        check("mid_rst_valid", 32'(sym_valid_o), 32'd0);
        check("mid_rst_sym", 32'(sym_o), 32'd0);
        check("mid_rst_ovf", 32'(overflow_o), 32'd0);
        reset = 1'b0;
        tick(80);
        check("mid_nosym", 32'(q_sym.size()), 32'd0);
        check("mid_end_state", 32'(dut.state_r), 32'(IDLE));
        check("mid_end_valid", 32'(sym_valid_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_morse_key_classifier
